// File: rtl/axi_transmit_pkg.sv
// Shared definitions for the transmit/receive packet link: packet-count
// helper and the transmitter state encoding.
package axi_transmit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Number of BUS_WIDTH packets needed to carry one DATA_WIDTH word (never 0).
  function automatic int packets_per_word(input int bus_w, input int data_w);
    int n;
    n = (data_w + bus_w - 1) / bus_w;
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/axi_transmit_if.sv
// Word-in / packet-out handshake bundle of the transmitter. The master
// modport is the transmitter's view; slave is the view of the logic around it.
interface axi_transmit_if
  import axi_transmit_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic [BUS_WIDTH-1:0]  packet;
  logic                  valid_pack;
  logic                  ready_pack;
  logic                  last_pack;
  logic                  busy;

  modport master (
    input  data_in, valid_in, ready_pack,
    output ready_out, packet, valid_pack, last_pack, busy
  );

  modport slave (
    output data_in, valid_in, ready_pack,
    input  ready_out, packet, valid_pack, last_pack, busy
  );

endinterface

// File: rtl/axi_transmit.sv
// Word-to-packet serializer: takes one DATA_WIDTH word over valid/ready and
// emits it as NUM_PACKETS BUS_WIDTH packets, least-significant chunk first.
// A new word can be taken on the cycle the final packet leaves, so words
// stream without a bubble.
module axi_transmit
  import axi_transmit_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  axi_transmit_if.master   bus
);

  localparam int NUM_PACKETS = packets_per_word(BUS_WIDTH, DATA_WIDTH);
  localparam int CNT_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int BUF_W       = NUM_PACKETS * BUS_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PACKETS - 1);

  tx_state_t            state;
  tx_state_t            state_nxt;
  logic [BUF_W-1:0]     shift_buf;
  logic [CNT_W-1:0]     pkt_cnt;

  logic                 ready_out_c;
  logic                 valid_pack_c;
  logic                 last_pack_c;
  logic                 busy_c;
  logic [BUS_WIDTH-1:0] packet_c;
  logic                 accept;
  logic                 send;

  assign accept = bus.valid_in && ready_out_c;
  assign send   = valid_pack_c && bus.ready_pack;

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave IDLE on accept, leave SEND only after the final packet
  // goes out with no replacement word arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (send && last_pack_c && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: in SEND the low chunk of the buffer is presented; ready_out in
  // SEND opens only as the final packet is consumed.
  always_comb begin
    ready_out_c  = 1'b1;
    valid_pack_c = 1'b0;
    last_pack_c  = 1'b0;
    busy_c       = 1'b0;
    packet_c     = '0;
    if (state == SEND) begin
      valid_pack_c = 1'b1;
      busy_c       = 1'b1;
      packet_c     = shift_buf[BUS_WIDTH-1:0];
      last_pack_c  = (pkt_cnt == LAST_CNT);
      ready_out_c  = last_pack_c && bus.ready_pack;
    end
  end

  // Shift buffer and packet counter: load (zero-extended) on accept, advance
  // one chunk per non-final send, hold while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_buf <= '0;
      pkt_cnt   <= '0;
    end else if (accept) begin
      shift_buf <= BUF_W'(bus.data_in);
      pkt_cnt   <= '0;
    end else if (send && !last_pack_c) begin
      shift_buf <= shift_buf >> BUS_WIDTH;
      pkt_cnt   <= pkt_cnt + CNT_W'(1);
    end
  end

  assign bus.ready_out  = ready_out_c;
  assign bus.valid_pack = valid_pack_c;
  assign bus.last_pack  = last_pack_c;
  assign bus.busy       = busy_c;
  assign bus.packet     = packet_c;

endmodule

// File: tb/tb_axi_transmit.sv
// Bench for axi_transmit: three instances (8/32, 32/16, 8/20 bus/data),
// driven by directed and random words. Each accepted word pushes its
// expected packets into a per-instance queue; negedge monitors pop and
// compare, and the 8/32 monitor also rebuilds words like the receiver does.
module tb_axi_transmit;

  typedef struct {
    logic [31:0] pkt;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_transmit_if #(.BUS_WIDTH(8),  .DATA_WIDTH(32)) ifa ();
  axi_transmit_if #(.BUS_WIDTH(32), .DATA_WIDTH(16)) ifb ();
  axi_transmit_if #(.BUS_WIDTH(8),  .DATA_WIDTH(20)) ifc ();

  axi_transmit #(.BUS_WIDTH(8),  .DATA_WIDTH(32)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  axi_transmit #(.BUS_WIDTH(32), .DATA_WIDTH(16)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  axi_transmit #(.BUS_WIDTH(8),  .DATA_WIDTH(20)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int total = 0;
  int bad   = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        q_c[$];
  logic [31:0] sent_q[$];

  exp_t        ea, eb, ec;
  logic [31:0] rx_word = '0;
  int          rx_idx  = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_pkt   = '0;
  logic        prev_last  = 1'b0;
  bit          bp_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a word becomes ceil(dw/bw) chunks of bw bits, low first.
  function automatic void model_word(input int sel, input logic [63:0] word,
                                     input int bw, input int dw);
    int          np;
    logic [63:0] w;
    exp_t        e;
    np = (dw + bw - 1) / bw;
    if (np < 1) np = 1;
    w = word & ((64'd1 << dw) - 64'd1);
    for (int i = 0; i < np; i++) begin
      e.pkt  = 32'((w >> (i * bw)) & ((64'd1 << bw) - 64'd1));
      e.last = (i == np - 1);
      case (sel)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endfunction

  // Monitor for the 8/32 instance: packet order, last flag, stall stability
  // and receiver-style reassembly.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("a_stall_valid", 32'(ifa.valid_pack), 32'd1);
        check("a_stall_packet", 32'(ifa.packet), 32'(prev_pkt));
        check("a_stall_last", 32'(ifa.last_pack), 32'(prev_last));
      end
      prev_stall = ifa.valid_pack && !ifa.ready_pack;
      prev_pkt   = ifa.packet;
      prev_last  = ifa.last_pack;
      if (ifa.valid_pack && ifa.ready_pack) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected: packet 0x%0h sent, expected none", ifa.packet);
        end else begin
          ea = q_a.pop_front();
          check("a_packet", 32'(ifa.packet), ea.pkt);
          check("a_last", 32'(ifa.last_pack), 32'(ea.last));
          rx_word = rx_word | (32'(ifa.packet) << (8 * rx_idx));
          rx_idx++;
          if (rx_idx == 4) begin
            if (sent_q.size() == 0) begin
              total++; bad++;
              $display("FAIL a_reassembled: word 0x%0h rebuilt, expected none", rx_word);
            end else begin
              check("a_reassembled", rx_word, sent_q.pop_front());
            end
            rx_word = '0;
            rx_idx  = 0;
          end
        end
      end
    end
  end

  // Monitor for the 32/16 instance.
  always @(negedge clk) begin
    if (!rst && ifb.valid_pack && ifb.ready_pack) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: packet 0x%0h sent, expected none", ifb.packet);
      end else begin
        eb = q_b.pop_front();
        check("b_packet", ifb.packet, eb.pkt);
        check("b_last", 32'(ifb.last_pack), 32'(eb.last));
      end
    end
  end

  // Monitor for the 8/20 instance.
  always @(negedge clk) begin
    if (!rst && ifc.valid_pack && ifc.ready_pack) begin
      if (q_c.size() == 0) begin
        total++; bad++;
        $display("FAIL c_unexpected: packet 0x%0h sent, expected none", ifc.packet);
      end else begin
        ec = q_c.pop_front();
        check("c_packet", 32'(ifc.packet), ec.pkt);
        check("c_last", 32'(ifc.last_pack), 32'(ec.last));
      end
    end
  end

  // Random downstream backpressure on the 8/32 instance.
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      ifa.ready_pack = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_a(input logic [31:0] w, input bit drop_valid);
    int n = 0;
    ifa.data_in  = w;
    ifa.valid_in = 1'b1;
    @(negedge clk);
    while (!ifa.ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifa.ready_out) begin
      total++; bad++;
      $display("FAIL a_accept_timeout: ready_out=%0b after %0d cycles, expected 1", ifa.ready_out, n);
      ifa.valid_in = 1'b0;
      return;
    end
    model_word(0, 64'(w), 8, 32);
    sent_q.push_back(w);
    @(posedge clk);
    #1;
    if (drop_valid) ifa.valid_in = 1'b0;
  endtask

  task automatic send_edge(input int sel, input logic [31:0] w);
    int   n = 0;
    logic rdy;
    if (sel == 1) begin ifb.data_in = w[15:0]; ifb.valid_in = 1'b1; end
    else          begin ifc.data_in = w[19:0]; ifc.valid_in = 1'b1; end
    @(negedge clk);
    rdy = (sel == 1) ? ifb.ready_out : ifc.ready_out;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = (sel == 1) ? ifb.ready_out : ifc.ready_out;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL edge_accept_timeout: inst %0d ready_out=0, expected 1", sel);
    end else if (sel == 1) begin
      model_word(1, 64'(w), 32, 16);
    end else begin
      model_word(2, 64'(w), 8, 20);
    end
    if (rdy) @(posedge clk);
    #1;
    ifb.valid_in = 1'b0;
    ifc.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d packets outstanding, expected 0",
               q_a.size() + q_b.size() + q_c.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    ifa.data_in = '0; ifa.valid_in = 1'b0; ifa.ready_pack = 1'b1;
    ifb.data_in = '0; ifb.valid_in = 1'b0; ifb.ready_pack = 1'b1;
    ifc.data_in = '0; ifc.valid_in = 1'b0; ifc.ready_pack = 1'b1;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_ready_out", 32'(ifa.ready_out), 32'd1);
    check("rst_valid_pack", 32'(ifa.valid_pack), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_packet", 32'(ifa.packet), 32'd0);
    check("rst_last_pack", 32'(ifa.last_pack), 32'd0);
    check("rst_b_packet", ifb.packet, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word: latency, last flag and ready_out timing
    send_a(32'hDEADBEEF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_valid", 32'(ifa.valid_pack), 32'd1);
      check("t1_last", 32'(ifa.last_pack), 32'(k == 3));
      check("t1_ready_out", 32'(ifa.ready_out), 32'(k == 3));
      check("t1_busy", 32'(ifa.busy), 32'd1);
    end
    @(negedge clk);
    check("t1_idle_valid", 32'(ifa.valid_pack), 32'd0);
    check("t1_idle_busy", 32'(ifa.busy), 32'd0);
    drain();

    // Back-to-back words with valid_in held: eight packets with no gap
    fork
      begin
        send_a(32'h11223344, 1'b0);
        send_a(32'hAABBCCDD, 1'b1);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!ifa.valid_pack && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 8; k++) begin
          check("t2_no_gap", 32'(ifa.valid_pack), 32'd1);
          if (k < 7) @(negedge clk);
        end
      end
    join
    drain();

    // Backpressure for three cycles on the third packet
    send_a(32'hDEADBEEF, 1'b1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 ifa.ready_pack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_packet", 32'(ifa.packet), 32'hAD);
      check("t3_hold_valid", 32'(ifa.valid_pack), 32'd1);
      @(posedge clk);
    end
    #1 ifa.ready_pack = 1'b1;
    drain();

    // Width edge cases
    send_edge(1, 32'h0000ABCD);
    send_edge(2, 32'h000FABCD);
    drain();
    for (int i = 0; i < 4; i++) begin
      w = $urandom();
      send_edge(1, w);
      w = $urandom();
      send_edge(2, w);
    end
    drain();

    // Asynchronous reset after the second packet
    send_a(32'hDEADBEEF, 1'b1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    q_a.delete();
    sent_q.delete();
    rx_word = '0;
    rx_idx  = 0;
    #1;
    check("t5_valid_pack", 32'(ifa.valid_pack), 32'd0);
    check("t5_busy", 32'(ifa.busy), 32'd0);
    check("t5_packet", 32'(ifa.packet), 32'd0);
    check("t5_ready_out", 32'(ifa.ready_out), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    send_a(32'hCAFEF00D, 1'b1);
    drain();

    // Random words, downstream always ready
    for (int i = 0; i < 16; i++) begin
      w = $urandom();
      send_a(w, ($urandom_range(0, 1) == 1));
      if (!ifa.valid_in) repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    ifa.valid_in = 1'b0;
    drain();

    // Random words under random backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = $urandom();
      send_a(w, ($urandom_range(0, 1) == 1));
    end
    ifa.valid_in = 1'b0;
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #2 ifa.ready_pack = 1'b1;
    drain();

    check("words_outstanding", 32'(sent_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
